// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   INSTR_W / PC_W    : instruction and program-counter widths
//   NOP_INSTR         : canonical rv32i NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT  : default fetch PC after reset
//   fetch_entry_t     : one buffered fetch, {pc, instr}
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          PC_W             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with a flush input and same-cycle
// push/pop. The read side is taken straight from storage at the head pointer
// so the consumer sees no combinational path from push/pop/flush.
// Ports:
//   clk      in  : rising-edge clock
//   reset    in  : asynchronous, active-low; clears pointers, count, storage
//   flush    in  : drop all entries and reset pointers; beats push/pop
//   push     in  : write wr_entry at the tail
//   pop      in  : remove the head
//   wr_entry in  : entry to write
//   rd_entry out : entry at the head (stale slot while empty)
//   full     out : count == DEPTH
//   empty    out : count == 0
// ---------------------------------------------------------------------------
import fetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves; a push
    // into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign rd_entry = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= wr_entry;
                tail      <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage between the program ROM and the rv32i core.
// Holds the fetch PC, drives the ROM word address and buffers fetched
// {pc, instr} pairs in fetch_fifo. A redirect flushes the buffer and
// restarts fetch at the new (word-aligned) PC.
// Ports:
//   clk            in  : rising-edge clock
//   reset          in  : asynchronous, active-low (0 = in reset)
//   rom_addr       out : ROM word address, fetch_pc[ADDR_W+1:2]
//   rom_data       in  : ROM read data for rom_addr, same cycle
//   redirect_valid in  : flush and restart request
//   redirect_pc    in  : restart PC, low two bits ignored
//   inst_valid     out : FIFO head holds a valid instruction
//   inst_ready     in  : decode accepts the head this cycle
//   inst           out : instruction at the FIFO head
//   inst_pc        out : byte PC of inst
//   fetch_pc       out : PC currently presented to the ROM
// ---------------------------------------------------------------------------
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst,
    output logic [PC_W-1:0]    inst_pc,
    output logic [PC_W-1:0]    fetch_pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] redirect_aligned;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    rd_entry;

    assign redirect_aligned = redirect_pc & ~PC_W'(3);

    assign inst_valid = !empty;
    assign pop        = inst_valid && inst_ready;
    // A redirect kills the push; the FIFO flush already discards any pop.
    assign push       = (!full || pop) && !redirect_valid;

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = rom_data;

    assign fetch_pc = pc_q;
    assign rom_addr = pc_q[ADDR_W+1:2];
    assign inst     = rd_entry.instr;
    assign inst_pc  = rd_entry.pc;

    // Fetch PC: redirect wins, otherwise advance one word per push.
    // The +4 wraps from 32'hFFFF_FFFC to 0 by plain modular arithmetic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_aligned;
        end else if (push) begin
            pc_q <= pc_q + PC_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (DEPTH = 4, ADDR_W = 5, RESET_PC = 0).
// The ROM model returns 32'h1000_0000 + word address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;

    int vectors;
    int miscompares;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4),
        .ADDR_W   (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_pc       (fetch_pc)
    );

    // Combinational ROM: word k holds 32'h1000_0000 + k.
    assign rom_data = 32'h1000_0000 + {27'd0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1 ns past it.
    task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rpc);
        inst_ready     = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        #2;
        checkOutput("rst_valid",    32'(inst_valid), 32'd0);
        checkOutput("rst_inst",     inst,            32'h0);
        checkOutput("rst_inst_pc",  inst_pc,         32'h0);
        checkOutput("rst_fetch_pc", fetch_pc,        32'h0);
        checkOutput("rst_rom_addr", 32'(rom_addr),   32'd0);

        @(posedge clk);
        #1;
        reset = 1'b1;

        // First edge after release pushes the word at RESET_PC
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("first_valid",    32'(inst_valid), 32'd1);
        checkOutput("first_inst_pc",  inst_pc,         32'h0);
        checkOutput("first_inst",     inst,            32'h1000_0000);
        checkOutput("first_fetch_pc", fetch_pc,        32'h4);

        // Backpressure: FIFO fills after 4 pushes, PC freezes at 0x10
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("bp_fetch_pc", fetch_pc,        32'h10);
        checkOutput("bp_rom_addr", 32'(rom_addr),   32'd4);
        checkOutput("bp_inst_pc",  inst_pc,         32'h0);
        checkOutput("bp_valid",    32'(inst_valid), 32'd1);

        // Release while full: one pop + one push per cycle, in order
        for (int j = 1; j <= 6; j++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("drain_valid",    32'(inst_valid), 32'd1);
            checkOutput("drain_inst_pc",  inst_pc,         32'(4 * j));
            checkOutput("drain_inst",     inst,            32'h1000_0000 + 32'(j));
            checkOutput("drain_fetch_pc", fetch_pc,        32'h10 + 32'(4 * j));
        end

        // Redirect to 0x80 (rom_addr aliases to word 0)
        applyStimulus(1'b0, 1'b1, 32'h0000_0080);
        checkOutput("rd80_valid",    32'(inst_valid), 32'd0);
        checkOutput("rd80_fetch_pc", fetch_pc,        32'h80);
        checkOutput("rd80_rom_addr", 32'(rom_addr),   32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("buf3_inst_pc",  inst_pc,  32'h80);
        checkOutput("buf3_inst",     inst,     32'h1000_0000);
        checkOutput("buf3_fetch_pc", fetch_pc, 32'h8C);

        // Redirect to 0x42 with 3 buffered and inst_ready high
        applyStimulus(1'b1, 1'b1, 32'h0000_0042);
        checkOutput("rd42_valid",    32'(inst_valid), 32'd0);
        checkOutput("rd42_fetch_pc", fetch_pc,        32'h40);
        checkOutput("rd42_rom_addr", 32'(rom_addr),   32'd16);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("rd42_new_valid",    32'(inst_valid), 32'd1);
        checkOutput("rd42_new_inst_pc",  inst_pc,         32'h40);
        checkOutput("rd42_new_inst",     inst,            32'h1000_0010);
        checkOutput("rd42_new_fetch_pc", fetch_pc,        32'h44);

        // PC wrap; low redirect bits are forced to zero
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("wrap_valid",    32'(inst_valid), 32'd0);
        checkOutput("wrap_fetch_pc", fetch_pc,        32'hFFFF_FFFC);
        checkOutput("wrap_rom_addr", 32'(rom_addr),   32'd31);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap_inst_pc0",  inst_pc,       32'hFFFF_FFFC);
        checkOutput("wrap_inst0",     inst,          32'h1000_001F);
        checkOutput("wrap_fetch_pc0", fetch_pc,      32'h0);
        checkOutput("wrap_rom_addr0", 32'(rom_addr), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("wrap_inst_pc1",  inst_pc,  32'h0);
        checkOutput("wrap_inst1",     inst,     32'h1000_0000);
        checkOutput("wrap_fetch_pc1", fetch_pc, 32'h4);

        // Fill again, then assert reset asynchronously mid-stream
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("full_fetch_pc", fetch_pc,        32'h10);
        checkOutput("full_valid",    32'(inst_valid), 32'd1);
        checkOutput("full_inst_pc",  inst_pc,         32'h0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_valid",    32'(inst_valid), 32'd0);
        checkOutput("arst_fetch_pc", fetch_pc,        32'h0);
        checkOutput("arst_inst_pc",  inst_pc,         32'h0);
        checkOutput("arst_inst",     inst,            32'h0);
        checkOutput("arst_rom_addr", 32'(rom_addr),   32'd0);
        @(posedge clk);
        #1;
        checkOutput("arst_hold_valid", 32'(inst_valid), 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("restart_valid",    32'(inst_valid), 32'd1);
        checkOutput("restart_inst_pc",  inst_pc,         32'h0);
        checkOutput("restart_inst",     inst,            32'h1000_0000);
        checkOutput("restart_fetch_pc", fetch_pc,        32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
